// File: rtl/counter_4_bits.sv
// rtl/counter_4_bits.sv - free-running up-counter with enable and synchronous reset
// Reset outranks enable; the value wraps modulo 2^WIDTH with the MSB carry dropped.
module counter_4_bits #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_count_inc;

  // Width-matched add: the carry out of the MSB falls off naturally.
  assign w_count_inc = r_count + {{(WIDTH-1){1'b0}}, 1'b1};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (enable) begin
      r_count <= w_count_inc;
    end
  end

  assign count = r_count;

endmodule

// File: tb/tb_counter_4_bits.sv
// tb/tb_counter_4_bits.sv - table-driven check of counter_4_bits against hand-computed values
// Inputs change on the falling edge; count is sampled 1 ns after each rising edge.
`timescale 1ns/1ps
module tb_counter_4_bits;

  typedef struct {
    logic       rst;
    logic       en;
    logic [3:0] exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [3:0] count;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [3:0] m_count;
  vec_t vecs[$];

  counter_4_bits #(.WIDTH(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .count  (count)
  );

  always #5 clk = ~clk;

  task automatic add_vec(input logic r, input logic e, input logic [3:0] x);
    vec_t v;
    v.rst = r;
    v.en  = e;
    v.exp = x;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: count=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_step(input logic r, input logic e);
    if (r) m_count = 4'd0;
    else if (e) m_count = m_count + 4'd1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: count=%0d required=finish at %0t", count, $time);
    $fatal(1, "timeout");
  end

  initial begin
    // Reset, ten counts, two holds, resume through wrap, reset priority.
    add_vec(1'b1, 1'b0, 4'd0);
    for (int i = 1; i <= 10; i++) add_vec(1'b0, 1'b1, 4'(i));
    add_vec(1'b0, 1'b0, 4'd10);
    add_vec(1'b0, 1'b0, 4'd10);
    add_vec(1'b0, 1'b1, 4'd11);
    add_vec(1'b0, 1'b1, 4'd12);
    add_vec(1'b0, 1'b1, 4'd13);
    add_vec(1'b0, 1'b1, 4'd14);
    add_vec(1'b0, 1'b1, 4'd15);
    add_vec(1'b0, 1'b1, 4'd0);
    add_vec(1'b0, 1'b1, 4'd1);
    add_vec(1'b0, 1'b1, 4'd2);
    add_vec(1'b1, 1'b1, 4'd0);
    add_vec(1'b1, 1'b1, 4'd0);
    add_vec(1'b0, 1'b1, 4'd1);
    add_vec(1'b0, 1'b0, 4'd1);
    add_vec(1'b0, 1'b1, 4'd2);

    m_count = 4'd0;
    for (int i = 0; i < vecs.size(); i++) begin
      rst    = vecs[i].rst;
      enable = vecs[i].en;
      model_step(vecs[i].rst, vecs[i].en);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), count, vecs[i].exp);
      if (i > 0) check($sformatf("model%0d", i), count, m_count);
      @(negedge clk);
    end

    // Mid-cycle rst pulse must not touch count before or at the next edge.
    rst = 1'b1;
    #1;
    check("async_rst", count, 4'd2);
    rst = 1'b0;
    enable = 1'b0;
    #1;
    check("rst_pulse_gap", count, 4'd2);
    @(posedge clk);
    #1;
    check("rst_pulse_edge", count, 4'd2);

    // Mid-cycle enable pulse is ignored unless it is present at the edge.
    @(negedge clk);
    enable = 1'b1;
    #2;
    check("en_between", count, 4'd2);
    enable = 1'b0;
    @(posedge clk);
    #1;
    check("en_pulse_edge", count, 4'd2);

    // Enable raised late in the cycle still counts exactly once.
    @(negedge clk);
    #3;
    enable = 1'b1;
    @(posedge clk);
    #1;
    check("late_en", count, 4'd3);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_midcount", count, 4'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("resume_from0", count, 4'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/counter_4_bits.md
COUNTER_4_BITS -- requirements
Module: counter_4_bits

Interface
REQ-001 The module SHALL have one clock and a reset that is synchronous and active-high.
REQ-002 Parameter: WIDTH, default 4, counter width in bits; the delivered configuration SHALL be WIDTH=4.
REQ-003 Port: clk  input  1  rising-edge clock; all state changes occur on the rising edge only.
REQ-004 Port: rst  input  1  synchronous active-high reset.
REQ-005 Port: enable  input  1  count enable; high means increment on the next rising edge.
REQ-006 Port: count  output  WIDTH (4)  current counter value, driven directly from a register.

Function
REQ-007 The count register SHALL update only on the rising edge of clk.
REQ-008 When rst=1 at a rising edge, count SHALL become 0 regardless of enable.
REQ-009 When rst=0 and enable=1 at a rising edge, count SHALL become (count+1) mod 2^WIDTH.
REQ-010 When rst=0 and enable=0 at a rising edge, count SHALL hold its value.
REQ-011 Priority SHALL be rst over enable.
REQ-012 Wrap-around: 4'b1111 with enable=1 SHALL go to 4'b0000 on the next edge, with no flag and no saturation.
REQ-013 Latency: each increment, hold or reset SHALL be visible on count immediately after the rising edge that samples it, with no extra pipeline stage.
REQ-014 The count output SHALL be purely registered, with no combinational path from enable or rst to count.
REQ-015 Inputs changing between clock edges SHALL have no effect until the next rising edge.
REQ-016 Arithmetic SHALL be unsigned modulo 2^WIDTH; the carry out of the MSB SHALL be discarded.

Reset
REQ-017 There SHALL be no asynchronous reset path; asserting rst between edges SHALL leave count unchanged until the next rising edge.
REQ-018 Before the first rising edge with rst=1, the value of count is undefined, and benches SHALL NOT check it.
REQ-019 Asserting rst mid-count SHALL force count to 0 at the next edge; counting SHALL resume from 0 on the first edge where rst=0 and enable=1.
REQ-020 Holding rst=1 for multiple edges SHALL keep count at 0.

Verification
REQ-021 Bench clock: 10 ns period, rising edges at 5, 15, 25 ns and so on.
- Reset: rst=1 and enable=0 through t=10 ns -> count=0 after the 5 ns edge.
- Counting: release rst and set enable=1 at t=10 -> count=1 after the 15 ns edge, and count=10 after the 105 ns edge (10 edges).
- Hold: enable=0 from t=110 to t=130 -> count remains 10 across the 115 and 125 ns edges.
- Resume and wrap: enable=1 at t=130 -> count=15 after the 175 ns edge, 0 after 185 ns, and 2 after 205 ns.
- Reset priority: rst=1 and enable=1 together at any edge -> count=0; deassert rst with enable=1 -> count=1 after the following edge.
- Mid-cycle stimulus: toggle rst or enable between edges -> no change on count until the next rising edge.
REQ-022 Benches SHALL check count just after each rising edge against a reference model: count_next = rst ? 0 : (enable ? count+1 mod 16 : count).
